// File: rtl/rca_multiword_add_ctrl.sv
// ---------------------------------------------------------------------------
// rca_multiword_add_ctrl
//   Multi-precision adder sequencer. One shared 16-bit ripple-carry adder
//   (rca_16b) processes one 16-bit slice per clock, least significant word
//   first. The carry between slices is held in a register. This trades
//   latency for area.
//
//   Optional feature macro: RCA_SUB_EN
//     When defined, a 'sub' input is added and the block computes A-B.
//     When undefined, the block is add-only.
//
// Ports
//   clk    in   1         clock; all state changes on the rising edge
//   rst    in   1         asynchronous, active-high reset
//   start  in   1         operation request; sampled only in IDLE
//   a, b   in   16*WORDS  operands; latched when start is accepted
//   c_in   in   1         carry into slice 0; latched when start is accepted
//   sub    in   1         (RCA_SUB_EN only) 1 = compute a-b; latched on accept
//   busy   out  1         high in RUN and DONE
//   done   out  1         one-cycle pulse; sum/c_out/ovf are valid from here
//   sum    out  16*WORDS  result register (slices are written progressively)
//   c_out  out  1         carry out of the top slice
//   ovf    out  1         two's-complement overflow of the full-width result
//
// Handshake: start is honoured only while busy is low. start pulses seen
// while busy is high are dropped, not queued. done rises exactly once per
// accepted start. The results hold until the next accepted start.
// ---------------------------------------------------------------------------

module rca_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    logic [16:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[16];
endmodule

module rca_multiword_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                c_in,
`ifdef RCA_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] sum,
    output logic                c_out,
    output logic                ovf
);
    localparam int W     = 16 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic               accept;
    logic               last;
    logic [15:0]        slice_a;
    logic [15:0]        slice_b;
    logic [15:0]        add_b;
    logic [15:0]        add_sum;
    logic               add_cout;
    logic               init_carry;

`ifdef RCA_SUB_EN
    logic               sub_q;
`endif

    assign accept = (state == S_IDLE) && start;
    assign last   = (idx == IDX_W'(WORDS - 1));

    // {idx, 4'b0} equals 16*idx, which selects the slice.
    assign slice_a = op_a[{idx, 4'b0000} +: 16];
    assign slice_b = op_b[{idx, 4'b0000} +: 16];

`ifdef RCA_SUB_EN
    // Subtraction is a + ~b + 1. The +1 comes from seeding the carry with 1.
    assign add_b      = sub_q ? ~slice_b : slice_b;
    assign init_carry = sub ? 1'b1 : c_in;
`else
    assign add_b      = slice_b;
    assign init_carry = c_in;
`endif

    rca_16b u_rca (
        .a     (slice_a),
        .b     (add_b),
        .c_in  (carry),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_RUN;
            S_RUN:   if (last)  next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN) || (state == S_DONE);
    assign done = (state == S_DONE);

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
`ifdef RCA_SUB_EN
            sub_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= init_carry;
                        idx   <= '0;
`ifdef RCA_SUB_EN
                        sub_q <= sub;
`endif
                    end
                end
                S_RUN: begin
                    sum[{idx, 4'b0000} +: 16] <= add_sum;
                    carry                     <= add_cout;
                    idx                       <= idx + IDX_W'(1);
                    if (last) begin
                        c_out <= add_cout;
                        // add_b[15] is the effective B sign bit (already
                        // inverted for subtraction).
                        ovf   <= (slice_a[15] == add_b[15]) &&
                                 (add_sum[15] != slice_a[15]);
                    end
                end
                S_DONE: begin
                    idx   <= '0;
                    // Clearing carry keeps state from leaking between operations.
                    carry <= 1'b0;
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rca_multiword_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rca_multiword_add_ctrl
//   Self-checking bench for rca_multiword_add_ctrl with WORDS=4. Expected
//   results come from a full-width reference model. They are queued when an
//   operation is issued and popped when done is seen. Build with
//   +define+RCA_SUB_EN to cover subtraction.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rca_multiword_add_ctrl;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;
    localparam int R     = W + 2;   // {sum, c_out, ovf}
    localparam int LAT   = WORDS + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    logic [R-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    rca_multiword_add_ctrl #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
`ifdef RCA_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [R-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        logic [W-1:0] bb;
        logic         ci;
        logic [W:0]   full;
        logic         v;
        bb   = msub ? ~mb : mb;
        ci   = msub ? 1'b1 : mcin;
        full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ci};
        v    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        return {full[W-1:0], full[W], v};
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a falling edge. Drives one request and queues its result.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic icin, input logic isub);
        a     = ia;
        b     = ib;
        c_in  = icin;
        sub   = isub;
        start = 1'b1;
        exp_q.push_back(model(ia, ib, icin, isub));
    endtask

    // Counts falling edges until done is seen. lat is -1 on timeout.
    // busy_ok reports whether busy was high on every sample up to done.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int done_cnt;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        sub   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, sum, c_out, ovf} !== '0)
            $display("FAIL reset_outputs: busy=%b done=%b sum=%h c_out=%b ovf=%b, required all 0",
                     busy, done, sum, c_out, ovf);
        else n_pass++;
        done_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        n_checks++;
        if (done_cnt !== 0)
            $display("FAIL reset_idle_quiet: %0d active samples, required 0", done_cnt);
        else n_pass++;
    endtask

    task automatic test_directed;
        logic [W-1:0] va[3];
        logic [W-1:0] vb[3];
        logic         vc[3];
        logic [R-1:0] req[3];
        logic [R-1:0] e;
        int           lat;
        logic         busy_ok;
        va[0] = 64'h0000_0000_0000_FFFF; vb[0] = 64'h1; vc[0] = 1'b0;
        req[0] = {64'h0000_0000_0001_0000, 1'b0, 1'b0};
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'h0; vc[1] = 1'b1;
        req[1] = {64'h0, 1'b1, 1'b0};
        va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'h1; vc[2] = 1'b0;
        req[2] = {64'h8000_0000_0000_0000, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            a     = va[i];
            b     = vb[i];
            c_in  = vc[i];
            sub   = 1'b0;
            start = 1'b1;
            exp_q.push_back(req[i]);
            wait_done(lat, busy_ok);
            n_checks++;
            if (lat !== LAT)
                $display("FAIL directed%0d_latency: got %0d cycles, required %0d", i, lat, LAT);
            else n_pass++;
            n_checks++;
            if (!busy_ok) $display("FAIL directed%0d_busy: busy low during op, required high", i);
            else n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if ({sum, c_out, ovf} !== e)
                $display("FAIL directed%0d_result: sum=%h c_out=%b ovf=%b, required sum=%h c_out=%b ovf=%b",
                         i, sum, c_out, ovf, e[R-1:2], e[1], e[0]);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL directed%0d_pulse: done=%b busy=%b, required 0 0", i, done, busy);
            else n_pass++;
            n_checks++;
            if ({sum, c_out, ovf} !== e)
                $display("FAIL directed%0d_hold: sum=%h c_out=%b ovf=%b, required values held",
                         i, sum, c_out, ovf);
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored;
        logic [R-1:0] e;
        int           lat;
        issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            start = 1'b1;
            a     = {$urandom, $urandom};
            b     = {$urandom, $urandom};
            c_in  = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        n_checks++;
        if (lat !== LAT)
            $display("FAIL ignore_latency: got %0d cycles, required %0d", lat, LAT);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if ({sum, c_out, ovf} !== e)
            $display("FAIL ignore_result: sum=%h c_out=%b ovf=%b, required sum=%h c_out=%b ovf=%b",
                     sum, c_out, ovf, e[R-1:2], e[1], e[0]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL ignore_no_queue: busy=%b done=%b, required 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_rst_mid_run;
        int           done_cnt;
        int           lat;
        logic         busy_ok;
        logic [R-1:0] e;
        a     = 64'hFFFF_FFFF_FFFF_FFFF;
        b     = 64'h1;
        c_in  = 1'b1;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);   // second RUN cycle; slice 0 is already written
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, sum, c_out, ovf} !== '0)
            $display("FAIL rst_abort_outputs: busy=%b done=%b sum=%h c_out=%b ovf=%b, required all 0",
                     busy, done, sum, c_out, ovf);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        n_checks++;
        if (done_cnt !== 0)
            $display("FAIL rst_abort_no_done: %0d done pulses, required 0", done_cnt);
        else n_pass++;
        issue(64'h0000_0001_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
        wait_done(lat, busy_ok);
        n_checks++;
        if (lat !== LAT)
            $display("FAIL rst_next_latency: got %0d cycles, required %0d", lat, LAT);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if ({sum, c_out, ovf} !== e)
            $display("FAIL rst_next_result: sum=%h c_out=%b ovf=%b, required sum=%h c_out=%b ovf=%b",
                     sum, c_out, ovf, e[R-1:2], e[1], e[0]);
        else n_pass++;
        @(negedge clk);
    endtask

`ifdef RCA_SUB_EN
    task automatic test_sub;
        int           lat;
        logic         busy_ok;
        logic [R-1:0] e;
        a     = 64'h5;
        b     = 64'h7;
        c_in  = 1'b0;
        sub   = 1'b1;
        start = 1'b1;
        exp_q.push_back({64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
        wait_done(lat, busy_ok);
        n_checks++;
        if (lat !== LAT)
            $display("FAIL sub_latency: got %0d cycles, required %0d", lat, LAT);
        else n_pass++;
        e = exp_q.pop_front();
        n_checks++;
        if ({sum, c_out, ovf} !== e)
            $display("FAIL sub_result: sum=%h c_out=%b ovf=%b, required sum=%h c_out=%b ovf=%b",
                     sum, c_out, ovf, e[R-1:2], e[1], e[0]);
        else n_pass++;
        sub = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_random;
        int           lat;
        logic         busy_ok;
        logic [R-1:0] e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        int           bad      = 0;
        int           bad_lat  = 0;
        for (int n = 0; n < 1000; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: ra = '1;
                1: rb = '1;
                2: ra = {1'b0, {(W-1){1'b1}}};
                3: rb = {1'b1, {(W-1){1'b0}}};
                default: ;
            endcase
`ifdef RCA_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            issue(ra, rb, 1'($urandom_range(0, 1)), rs);
            wait_done(lat, busy_ok);
            if (lat !== LAT) bad_lat++;
            e = exp_q.pop_front();
            n_checks++;
            if ({sum, c_out, ovf} !== e) begin
                if (bad < 5)
                    $display("FAIL random%0d_result: sum=%h c_out=%b ovf=%b, required sum=%h c_out=%b ovf=%b",
                             n, sum, c_out, ovf, e[R-1:2], e[1], e[0]);
                bad++;
            end else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (bad_lat !== 0)
            $display("FAIL random_latency: %0d ops with wrong latency, required 0", bad_lat);
        else n_pass++;
        n_checks++;
        if (exp_q.size() !== 0)
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        else n_pass++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_rst_mid_run();
`ifdef RCA_SUB_EN
        test_sub();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
